score_ssd_driver: RTL and testbench

Drives the four-digit seven-segment display from the 16-bit game score, feeding the segment and anode nets of the top level.
A sequential double-dabble converter turns the binary score into four BCD digits. A free-running scan counter time-multiplexes those digits onto the active-low anodes and segments. Leading zeros are optionally blanked.

---
 rtl/score_ssd_driver_if.sv | 11 +
 rtl/score_ssd_driver.sv | 158 +++++++++++++++
 tb/tb_score_ssd_driver.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/score_ssd_driver_if.sv
// Score-to-display bus: binary score in, multiplexed segment/anode drive and
// converter status out.
interface score_ssd_driver_if;
  logic [15:0] Score;
  logic [6:0]  SsdOut;
  logic [3:0]  Anode;
  logic        Busy;

  modport master (output Score, input SsdOut, input Anode, input Busy);
  modport slave  (input Score, output SsdOut, output Anode, output Busy);
endinterface

// File: rtl/score_ssd_driver.sv
// Four-digit seven-segment driver: sequential double-dabble of the score into
// BCD digits, time-multiplexed onto active-low anodes/segments.
//
// state | meaning
// IDLE  | waiting for Score to differ from the last captured value
// CONV  | 16 shift/add-3 iterations of the double-dabble
// DONE  | commit BCD result to the displayed digit registers
module score_ssd_driver #(
  parameter int SCAN_DIV = 17,
  parameter bit LZ_BLANK = 1'b1
) (
  input logic           Clk,
  input logic           Reset,
  score_ssd_driver_if.slave bus
);

  localparam int SCAN_W = SCAN_DIV + 2;

  typedef enum logic [1:0] {IDLE, CONV, DONE} convState_t;

  convState_t  state, nextState;
  logic [15:0] lastValue;
  logic [15:0] shiftReg;
  logic [15:0] bcdAcc;
  logic [3:0]  iterCnt;
  logic [15:0] digits;
  logic [SCAN_W-1:0] scanCnt;

  logic        loadConv;
  logic        stepConv;
  logic        commitDigits;
  logic [15:0] satScore;
  logic [15:0] bcdAdj;
  logic [15:0] bcdNext;
  logic [15:0] shiftNext;

  logic [1:0]  digitIdx;
  logic [3:0]  selDigit;
  logic        blankDigit;
  logic [6:0]  segNext;

  function automatic logic [6:0] decodeSeg(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  assign satScore = (bus.Score > 16'd9999) ? 16'd9999 : bus.Score;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState    = state;
    loadConv     = 1'b0;
    stepConv     = 1'b0;
    commitDigits = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Score != lastValue) begin
          loadConv  = 1'b1;
          nextState = CONV;
        end
      end
      CONV: begin
        stepConv = 1'b1;
        if (iterCnt == 4'd15) nextState = DONE;
      end
      DONE: begin
        commitDigits = 1'b1;
        nextState    = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Add-3 correction on every nibble before the combined left shift.
  always_comb begin
    bcdAdj = bcdAcc;
    for (int i = 0; i < 4; i++) begin
      if (bcdAcc[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcdAcc[4*i +: 4] + 4'd3;
    end
    bcdNext   = {bcdAdj[14:0], shiftReg[15]};
    shiftNext = {shiftReg[14:0], 1'b0};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lastValue <= '0;
      shiftReg  <= '0;
      bcdAcc    <= '0;
      iterCnt   <= '0;
      digits    <= '0;
    end else begin
      if (loadConv) begin
        lastValue <= bus.Score;
        shiftReg  <= satScore;
        bcdAcc    <= '0;
        iterCnt   <= '0;
      end else if (stepConv) begin
        shiftReg <= shiftNext;
        bcdAcc   <= bcdNext;
        iterCnt  <= iterCnt + 4'd1;
      end
      if (commitDigits) digits <= bcdAcc;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) scanCnt <= '0;
    else       scanCnt <= scanCnt + SCAN_W'(1);
  end

  assign digitIdx = scanCnt[SCAN_W-1 -: 2];
  assign selDigit = digits[{digitIdx, 2'b00} +: 4];

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    blankDigit = 1'b0;
    if (LZ_BLANK) begin
      case (digitIdx)
        2'd1:    blankDigit = (digits[15:4]  == 12'd0);
        2'd2:    blankDigit = (digits[15:8]  == 8'd0);
        2'd3:    blankDigit = (digits[15:12] == 4'd0);
        default: blankDigit = 1'b0;
      endcase
    end
  end

  assign segNext = blankDigit ? 7'b1111111 : decodeSeg(selDigit);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.SsdOut <= 7'b0000001;
      bus.Anode  <= 4'b1110;
    end else begin
      bus.SsdOut <= segNext;
      bus.Anode  <= ~(4'b0001 << digitIdx);
    end
  end

  assign bus.Busy = (state != IDLE);

endmodule

// File: tb/tb_score_ssd_driver.sv
// Bench for score_ssd_driver: two instances (leading-zero blanking on/off) share
// clock, reset and score; every cycle is compared to a decimal display model.
module tb_score_ssd_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] score = 16'd0;
  int          edgeCnt = 0;
  int          checks = 0;
  int          errors = 0;
  int unsigned prevScore = 0;

  logic [6:0] segTab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100};

  score_ssd_driver_if ifA ();
  score_ssd_driver_if ifB ();

  assign ifA.Score = score;
  assign ifB.Score = score;

  score_ssd_driver #(.SCAN_DIV(2), .LZ_BLANK(1'b1)) dutA (
    .Clk(clk), .Reset(rst), .bus(ifA.slave)
  );
  score_ssd_driver #(.SCAN_DIV(2), .LZ_BLANK(1'b0)) dutB (
    .Clk(clk), .Reset(rst), .bus(ifB.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) edgeCnt <= 0;
    else     edgeCnt <= edgeCnt + 1;
  end

  // Displayed pattern for decimal position idx of a (saturated) score.
  function automatic logic [6:0] expSeg(input int unsigned sc, input int idx, input bit lz);
    int unsigned sat;
    int unsigned p;
    sat = (sc > 9999) ? 9999 : sc;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (lz && idx > 0 && sat < p) return 7'b1111111;
    return segTab[(sat / p) % 10];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output slot after k edges since reset release: reset value first, then the
  // slot selected one cycle earlier, each lasting 4 cycles.
  task automatic checkCycle(input int unsigned dispScore, input int expBusy);
    int idx;
    logic [3:0] expAn;
    idx = (edgeCnt == 0) ? 0 : (((edgeCnt - 1) >> 2) & 3);
    expAn = ~(4'b0001 << idx);
    chk("anodeA", {12'd0, ifA.Anode}, {12'd0, expAn});
    chk("anodeB", {12'd0, ifB.Anode}, {12'd0, expAn});
    chk("segA", {9'd0, ifA.SsdOut}, {9'd0, expSeg(dispScore, idx, 1'b1)});
    chk("segB", {9'd0, ifB.SsdOut}, {9'd0, expSeg(dispScore, idx, 1'b0)});
    if (expBusy >= 0) begin
      chk("busyA", {15'd0, ifA.Busy}, 16'(expBusy));
      chk("busyB", {15'd0, ifB.Busy}, 16'(expBusy));
    end
  endtask

  task automatic checkReset();
    chk("rstSegA", {9'd0, ifA.SsdOut}, 16'h0001);
    chk("rstSegB", {9'd0, ifB.SsdOut}, 16'h0001);
    chk("rstAnA", {12'd0, ifA.Anode}, 16'h000E);
    chk("rstAnB", {12'd0, ifB.Anode}, 16'h000E);
    chk("rstBusyA", {15'd0, ifA.Busy}, 16'd0);
    chk("rstBusyB", {15'd0, ifB.Busy}, 16'd0);
  endtask

  // Drive a new score; the old value stays on display until 18 edges later,
  // Busy covers the 17 edges of the conversion, then one full frame is checked.
  task automatic convWait(input int unsigned oldDisp, input int unsigned newScore,
                          input int chg1At, input int unsigned chg1Val,
                          input int chg2At, input int unsigned chg2Val);
    score = 16'(newScore);
    for (int j = 0; j < 18; j++) begin
      tick();
      checkCycle(oldDisp, (j < 17) ? 1 : 0);
      if (j == chg1At) score = 16'(chg1Val);
      if (j == chg2At) score = 16'(chg2Val);
    end
    if (chg1At < 0 && chg2At < 0) begin
      for (int j = 0; j < 16; j++) begin
        tick();
        checkCycle(newScore, 0);
      end
      prevScore = newScore;
    end
  endtask

  initial begin
    rst = 1'b1;
    score = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    checkReset();
    rst = 1'b0;

    // Idle display of zero across two frames.
    for (int j = 0; j < 32; j++) begin
      tick();
      checkCycle(0, 0);
    end

    convWait(0, 1234, -1, 0, -1, 0);
    convWait(1234, 65535, -1, 0, -1, 0);
    convWait(65535, 10000, -1, 0, -1, 0);
    convWait(10000, 9999, -1, 0, -1, 0);

    // Changes during a conversion collapse to the final value.
    convWait(9999, 1234, 2, 0, 4, 5);
    convWait(1234, 5, -1, 0, -1, 0);
    convWait(5, 7, -1, 0, -1, 0);
    convWait(7, 0, -1, 0, -1, 0);
    convWait(0, 1000, -1, 0, -1, 0);

    // Reset in the middle of a conversion.
    score = 16'd4321;
    for (int j = 0; j < 6; j++) begin
      tick();
      checkCycle(1000, 1);
    end
    rst = 1'b1;
    #1;
    checkReset();
    repeat (2) tick();
    checkReset();
    rst = 1'b0;
    convWait(0, 4321, -1, 0, -1, 0);

    for (int n = 0; n < 24; n++) begin
      int unsigned v;
      v = $urandom_range(0, 65535) >> $urandom_range(0, 12);
      if (v == prevScore) v = v ^ 1;
      convWait(prevScore, v, -1, 0, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
